// File: rtl/elevator_ctrl_n.sv
// elevator_ctrl_n
//   Parametrised elevator controller with latched call requests and a SCAN
//   (direction-preserving) scheduler. Travel and door timing are counted in
//   single-clock `tick` pulses from the frequency divider.
//
// Parameters:
//   FLOORS       number of floors (2..16)
//   TRAVEL_TICKS tick pulses needed to move one floor (>= 1)
//   DOOR_TICKS   tick pulses the door stays open (>= 1)
//
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   tick    one-clk-wide timing pulse
//   call    level-sensitive call buttons, bit i = floor i
//   led     latched pending requests
//   floor   one-hot current car position
//   door    door open
//   moving  car travelling
//   dir_up  current/last travel direction, 1 = up
//
// Optional feature macro: DOOR_REOPEN_EN
//   When defined, a call at the current floor while the door is open restarts
//   the door timer. When undefined such a call is ignored.

module elevator_ctrl_n #(
  parameter int FLOORS       = 3,
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [FLOORS-1:0] call,
  output logic [FLOORS-1:0] led,
  output logic [FLOORS-1:0] floor,
  output logic              door,
  output logic              moving,
  output logic              dir_up
);

  localparam int POS_W     = $clog2(FLOORS);
  localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int TIMER_W   = $clog2(MAX_TICKS + 1);

  localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_TICKS - 1);
  localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE      = 2'd1,
    DOOR_OPEN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [FLOORS-1:0]   led_q, led_d;
  logic [FLOORS-1:0]   floor_q, floor_d;
  logic                door_q, door_d;
  logic                moving_q, moving_d;
  logic                dir_up_q, dir_up_d;

  logic [FLOORS-1:0]   here;
  logic [FLOORS-1:0]   above;
  logic [FLOORS-1:0]   below;
  logic [FLOORS-1:0]   call_ok;
  logic [FLOORS-1:0]   led_clr;
  logic [POS_W-1:0]    pos_step;
  logic                req_up;
  logic                req_dn;
  logic                reopen;

  always_comb begin
    here  = FLOORS'(1) << pos_q;
    above = '0;
    below = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (i > int'(pos_q)) above[i] = 1'b1;
      if (i < int'(pos_q)) below[i] = 1'b1;
    end
    req_up = |(led_q & above);
    req_dn = |(led_q & below);

    // While the car stands at a floor (idle or door open) a press of that
    // floor's own button is never latched; it is served by the door instead.
    call_ok = call;
    if (state_q != MOVE) call_ok = call & ~here;

`ifdef DOOR_REOPEN_EN
    reopen = |(call & here);
`else
    reopen = 1'b0;
`endif

    pos_step = dir_up_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));

    state_d  = state_q;
    pos_d    = pos_q;
    timer_d  = timer_q;
    dir_up_d = dir_up_q;
    led_clr  = '0;

    case (state_q)
      IDLE: begin
        if (((call | led_q) & here) != '0) begin
          state_d = DOOR_OPEN;
          timer_d = '0;
          led_clr = here;
        end else if (led_q != '0) begin
          // SCAN: keep the current direction while work remains ahead.
          if (!(dir_up_q ? req_up : req_dn)) dir_up_d = ~dir_up_q;
          state_d = MOVE;
          timer_d = '0;
        end
      end

      MOVE: begin
        if (tick) begin
          if (timer_q == TRAVEL_LAST) begin
            pos_d   = pos_step;
            timer_d = '0;
            if (led_q[pos_step]) begin
              state_d = DOOR_OPEN;
              led_clr = FLOORS'(1) << pos_step;
            end
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end

      DOOR_OPEN: begin
        if (reopen) begin
          timer_d = '0;
        end else if (tick) begin
          if (timer_q == DOOR_LAST) begin
            state_d = IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // A clear on arrival wins over a press of the same floor on that edge.
    led_d    = (led_q | call_ok) & ~led_clr;
    floor_d  = FLOORS'(1) << pos_d;
    door_d   = (state_d == DOOR_OPEN);
    moving_d = (state_d == MOVE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pos_q    <= '0;
      timer_q  <= '0;
      led_q    <= '0;
      floor_q  <= FLOORS'(1);
      door_q   <= 1'b0;
      moving_q <= 1'b0;
      dir_up_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      timer_q  <= timer_d;
      led_q    <= led_d;
      floor_q  <= floor_d;
      door_q   <= door_d;
      moving_q <= moving_d;
      dir_up_q <= dir_up_d;
    end
  end

  assign led    = led_q;
  assign floor  = floor_q;
  assign door   = door_q;
  assign moving = moving_q;
  assign dir_up = dir_up_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb_elevator_ctrl_n
//   Scoreboard bench for elevator_ctrl_n. Each cycle the stimulus process
//   drives call/tick, advances a floor-level reference model of the car and
//   queues the outputs it expects after the next clock edge; a separate monitor
//   pops and compares after every rising edge. Asynchronous resets are fired at
//   random points (favouring mid-travel) and checked immediately.

module tb_elevator_ctrl_n;

  localparam int F      = 4;
  localparam int TRAVEL = 4;
  localparam int DOOR   = 3;
  localparam int CYCLES = 3000;

  localparam int M_IDLE   = 0;
  localparam int M_TRAVEL = 1;
  localparam int M_DOOR   = 2;

  typedef struct packed {
    logic [F-1:0] led;
    logic [F-1:0] floor;
    logic         door;
    logic         moving;
    logic         dirUp;
  } outs_t;

  logic         clk;
  logic         rst_n;
  logic         tick;
  logic [F-1:0] call;
  logic [F-1:0] led;
  logic [F-1:0] floor;
  logic         door;
  logic         moving;
  logic         dir_up;

  int checks   = 0;
  int failures = 0;

  outs_t expQ[$];

  // Reference model: where the car is, what it is doing, how many ticks of the
  // current activity remain, and which floors are still waiting.
  int mPos;
  int mMode;
  int mLeft;
  bit mUp;
  bit mReq[F];

  elevator_ctrl_n #(
    .FLOORS      (F),
    .TRAVEL_TICKS(TRAVEL),
    .DOOR_TICKS  (DOOR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .call  (call),
    .led   (led),
    .floor (floor),
    .door  (door),
    .moving(moving),
    .dir_up(dir_up)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends even if something stalls.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic outs_t modelOutputs();
    outs_t o;
    o.led = '0;
    for (int i = 0; i < F; i++) o.led[i] = mReq[i];
    o.floor  = '0;
    o.floor[mPos] = 1'b1;
    o.door   = (mMode == M_DOOR);
    o.moving = (mMode == M_TRAVEL);
    o.dirUp  = mUp;
    return o;
  endfunction

  task automatic resetModel();
    mPos  = 0;
    mMode = M_IDLE;
    mLeft = 0;
    mUp   = 1'b1;
    for (int i = 0; i < F; i++) mReq[i] = 1'b0;
  endtask

  // Advance the reference by one clock edge given the inputs seen at that edge.
  task automatic stepModel(input logic [F-1:0] c, input logic t);
    bit nReq[F];
    bit anyReq, anyAbove, anyBelow, reopen;
    int np;
    nReq = mReq;
    for (int i = 0; i < F; i++)
      if (c[i] && !(i == mPos && mMode != M_TRAVEL)) nReq[i] = 1'b1;
    anyReq = 0; anyAbove = 0; anyBelow = 0;
    for (int i = 0; i < F; i++)
      if (mReq[i]) begin
        anyReq = 1;
        if (i > mPos) anyAbove = 1;
        if (i < mPos) anyBelow = 1;
      end
`ifdef DOOR_REOPEN_EN
    reopen = c[mPos];
`else
    reopen = 0;
`endif
    case (mMode)
      M_IDLE: begin
        if (c[mPos] || mReq[mPos]) begin
          mMode = M_DOOR;
          mLeft = DOOR;
          nReq[mPos] = 1'b0;
        end else if (anyReq) begin
          if (!(mUp ? anyAbove : anyBelow)) mUp = !mUp;
          mMode = M_TRAVEL;
          mLeft = TRAVEL;
        end
      end
      M_TRAVEL: begin
        if (t) begin
          mLeft--;
          if (mLeft == 0) begin
            np = mUp ? mPos + 1 : mPos - 1;
            if (np < 0 || np >= F) begin
              failures++;
              $display("[TB] FAIL model_range position=%0d required 0..%0d", np, F - 1);
              np = mPos;
            end
            mPos = np;
            if (mReq[np]) begin
              nReq[np] = 1'b0;
              mMode = M_DOOR;
              mLeft = DOOR;
            end else begin
              mLeft = TRAVEL;
            end
          end
        end
      end
      default: begin
        if (reopen) mLeft = DOOR;
        else if (t) begin
          mLeft--;
          if (mLeft == 0) mMode = M_IDLE;
        end
      end
    endcase
    mReq = nReq;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    outs_t act;
    act = {led, floor, door, moving, dir_up};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got led=%b floor=%b door=%b moving=%b dir_up=%b, required led=%b floor=%b door=%b moving=%b dir_up=%b",
               name, $time, act.led, act.floor, act.door, act.moving, act.dirUp,
               exp.led, exp.floor, exp.door, exp.moving, exp.dirUp);
    end
  endtask

  // Drive one cycle of inputs and queue what the car should show after the edge.
  task automatic applyStimulus(input logic [F-1:0] c, input logic t);
    call = c;
    tick = t;
    stepModel(c, t);
    expQ.push_back(modelOutputs());
  endtask

  // Asynchronous reset pulse in the middle of a low clock phase; outputs must
  // drop to reset values without waiting for an edge.
  task automatic applyReset();
    outs_t rv;
    call = '0;
    tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    rv.led = '0; rv.floor = F'(1); rv.door = 0; rv.moving = 0; rv.dirUp = 1;
    checkOutput("async_reset", rv);
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
  endtask

  // Monitor: compares the DUT against the oldest queued expectation just after
  // each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput("cycle", expQ.pop_front());
    end
  end

  // Stimulus: a short scripted opening (far call, then a call for the floor
  // being passed) followed by randomized calls and tick patterns.
  initial begin
    logic [F-1:0] c;
    logic         t;
    logic [F-1:0] scriptCall[14];
    scriptCall = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000,
                   4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    call  = '0;
    tick  = 1'b0;
    rst_n = 1'b1;
    resetModel();
    @(negedge clk);
    applyReset();

    for (int i = 0; i < 14; i++) begin
      applyStimulus(scriptCall[i], 1'b1);
      @(negedge clk);
    end

    for (int n = 0; n < CYCLES; n++) begin
      if ((mMode == M_TRAVEL && $urandom_range(0, 79) == 0) || $urandom_range(0, 599) == 0)
        applyReset();
      c = '0;
      if ($urandom_range(0, 5) == 0) c[$urandom_range(0, F - 1)] = 1'b1;
      if ($urandom_range(0, 19) == 0) c = F'($urandom);
      if (n < CYCLES / 3) t = 1'b1;
      else                t = ($urandom_range(0, 2) == 0);
      applyStimulus(c, t);
      @(negedge clk);
    end

    applyStimulus('0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
